sequence_load_controller: RTL and testbench

//   Sequences the loading of one query/database word pair per beat into sequence_buffer.

---
 rtl/sequence_load_controller.sv | 128 ++++++++++++
 tb/tb_sequence_load_controller.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sequence_load_controller.sv
// ---------------------------------------------------------------------------
// sequence_load_controller
//
// Loads one query/database word pair per accepted beat into sequence_buffer.
// Once NUM_REG beats have been written, it pulses core_start to the alignment
// core. It then waits for core_done before it will accept another job.
//
// Ports
//   clk         in   1      single clock, all logic on posedge
//   rst         in   1      synchronous reset, active-high
//   start       in   1      job request, honoured only while idle
//   abort       in   1      cancel current job, honoured in any busy state
//   in_valid    in   1      host presents a word pair this cycle
//   in_ready    out  1      controller accepts the word pair this cycle
//   wr_en_buff  out  1      write strobe to sequence_buffer
//   count       out  CNT_W  write index to sequence_buffer
//   core_start  out  1      one-cycle pulse: buffer full, core may begin
//   core_done   in   1      core finished, only looked at while running
//   busy        out  1      high whenever a job is in progress
//   job_done    out  1      one-cycle pulse after core_done is accepted
// ---------------------------------------------------------------------------
module sequence_load_controller #(
  parameter  int NUM_REG = 8,
  localparam int CNT_W   = $clog2(NUM_REG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             wr_en_buff,
  output logic [CNT_W-1:0] count,
  output logic             core_start,
  input  logic             core_done,
  output logic             busy,
  output logic             job_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_RUN
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic             r_job_done;
  logic             w_beat;
  logic             w_last_beat;

  // abort takes precedence over a beat, so an aborted cycle never writes.
  assign w_beat      = in_valid & (r_state == S_LOAD) & ~abort;
  assign w_last_beat = w_beat & (r_count == CNT_W'(NUM_REG - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (abort)            w_state_nxt = S_IDLE;
        else if (w_last_beat) w_state_nxt = S_START;
      end
      S_START: begin
        w_state_nxt = abort ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        if (abort || core_done) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Write index. It is cleared whenever the job is idle or aborted. It
  // advances only on accepted beats. The power-of-two depth lets the
  // increment after the last beat wrap naturally to 0.
  always_ff @(posedge clk) begin
    if (rst || (r_state == S_IDLE) || abort) begin
      r_count <= '0;
    end else if (w_beat) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // job_done is registered so it appears the cycle after core_done.
  // An abort in the same cycle cancels it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_job_done <= 1'b0;
    end else begin
      r_job_done <= (r_state == S_RUN) & core_done & ~abort;
    end
  end

  // Output logic. Outputs are forced low while rst is asserted, so nothing
  // leaks out in the reset cycle itself, before the state register clears.
  always_comb begin
    in_ready   = 1'b0;
    wr_en_buff = 1'b0;
    count      = '0;
    core_start = 1'b0;
    busy       = 1'b0;
    job_done   = 1'b0;
    if (!rst) begin
      in_ready   = (r_state == S_LOAD) & ~abort;
      wr_en_buff = w_beat;
      count      = r_count;
      core_start = (r_state == S_START);
      busy       = (r_state != S_IDLE);
      job_done   = r_job_done;
    end
  end

endmodule

// File: tb/tb_sequence_load_controller.sv
module tb_sequence_load_controller;

  localparam int N  = 8;
  localparam int CW = $clog2(N);
  localparam int VW = 5 + CW;

  logic          clk;
  logic          rst;
  logic          start;
  logic          abort;
  logic          in_valid;
  logic          in_ready;
  logic          wr_en_buff;
  logic [CW-1:0] count;
  logic          core_start;
  logic          core_done;
  logic          busy;
  logic          job_done;

  sequence_load_controller #(.NUM_REG(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .wr_en_buff (wr_en_buff),
    .count      (count),
    .core_start (core_start),
    .core_done  (core_done),
    .busy       (busy),
    .job_done   (job_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: one expected output vector per cycle, in the order
  // {in_ready, wr_en_buff, core_start, busy, job_done, count}.
  logic [VW-1:0] exp_q[$];
  int            n_vec  = 0;
  int            n_miss = 0;

  // Reference model kept at the job level. It tracks whether a job exists,
  // how many beats it has loaded, and whether the core has been handed off.
  bit m_active  = 0;
  int m_loaded  = 0;
  bit m_started = 0;
  bit m_jd_pend = 0;

  function automatic bit m_loading();
    return m_active && (m_loaded < N);
  endfunction
  function automatic bit m_handoff();
    return m_active && (m_loaded == N) && !m_started;
  endfunction
  function automatic bit m_running();
    return m_active && m_started;
  endfunction

  // Applies one cycle of inputs. It pushes the expected outputs for this
  // cycle, then advances the model across the clock edge.
  task automatic step(input bit r, input bit st, input bit ab, input bit iv, input bit cd);
    bit            e_rdy;
    bit            e_wr;
    bit            e_cs;
    bit            e_busy;
    bit            e_jd;
    logic [CW-1:0] e_cnt;
    rst = r; start = st; abort = ab; in_valid = iv; core_done = cd;
    e_rdy  = !r && m_loading() && !ab;
    e_wr   = e_rdy && iv;
    e_cs   = !r && m_handoff();
    e_busy = !r && m_active;
    e_jd   = !r && m_jd_pend;
    e_cnt  = r ? '0 : CW'(m_loaded % N);
    exp_q.push_back({e_rdy, e_wr, e_cs, e_busy, e_jd, e_cnt});
    @(posedge clk);
    if (r) begin
      m_active = 0; m_loaded = 0; m_started = 0; m_jd_pend = 0;
    end else begin
      m_jd_pend = m_running() && cd && !ab;
      if (!m_active) begin
        if (st) begin
          m_active = 1; m_loaded = 0; m_started = 0;
        end
      end else if (ab) begin
        m_active = 0; m_loaded = 0; m_started = 0;
      end else if (m_loading()) begin
        if (iv) m_loaded++;
      end else if (m_handoff()) begin
        m_started = 1;
      end else if (cd) begin
        m_active = 0; m_loaded = 0; m_started = 0;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  // Starts a job, loads it completely, and passes the handoff cycle.
  task automatic go_to_run();
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 4 * N && m_loading(); i++) step(0, 0, 0, $urandom_range(0, 3) != 0, 0);
    step(0, 0, 0, 0, 0);
  endtask

  // Monitor: samples mid-cycle, away from the active edge.
  always @(negedge clk) begin
    logic [VW-1:0] exp_v;
    logic [VW-1:0] act_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {in_ready, wr_en_buff, core_start, busy, job_done, count};
      n_vec++;
      if (act_v !== exp_v) begin
        n_miss++;
        $display("FAIL outputs t=%0t {rdy,wr,cs,busy,jd,cnt} got=%b expected=%b", $time, act_v, exp_v);
      end
    end
  end

  initial begin
    rst = 1; start = 0; abort = 0; in_valid = 0; core_done = 0;
    @(posedge clk); #1;
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 1, 1);
    idle(2);

    // Straight-through load with in_valid held high.
    step(0, 1, 0, 1, 0);
    for (int i = 0; i < N; i++) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    idle(3);
    step(0, 0, 0, 0, 1);
    idle(2);

    // Backpressure: in_valid alternates.
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 4 * N && m_loading(); i++) step(0, 0, 0, i[0] == 1'b0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    idle(1);

    // Abort at count 3, then a fresh job that completes.
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
    step(0, 0, 1, 1, 0);
    idle(2);
    go_to_run();
    step(0, 0, 0, 0, 1);
    idle(1);

    // While running, start and in_valid are ignored; core_done arrives late.
    go_to_run();
    step(0, 1, 0, 1, 0);
    idle(19);
    step(0, 0, 0, 0, 1);
    idle(2);

    // Abort together with the final beat.
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < N - 1; i++) step(0, 0, 0, 1, 0);
    step(0, 0, 1, 1, 0);
    idle(2);

    // Abort during the handoff cycle, then abort together with core_done.
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < N; i++) step(0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0);
    idle(1);
    go_to_run();
    step(0, 0, 1, 0, 1);
    idle(2);

    // Reset during a running job; a later core_done is ignored.
    go_to_run();
    idle(2);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    idle(3);

    // start held high through job_done chains straight into a new job.
    go_to_run();
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 30,
           $urandom_range(0, 99) < 4,
           $urandom_range(0, 99) < 70,
           $urandom_range(0, 99) < 15);
    end
    idle(2);

    @(negedge clk); #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
